// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, full flag set and iterative signed multiply.
module alu_seq #(
    parameter int data_width    = 8,
    parameter int op_code_width = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [op_code_width-1:0] OP,
    input  logic [data_width-1:0]    data_in,
    input  logic [data_width-1:0]    cr_in,
    input  logic                     cy_in,
    output logic                     out_valid,
    output logic [data_width-1:0]    data_out,
    output logic                     cy,
    output logic                     ov,
    output logic                     z,
    output logic                     n,
    output logic                     busy
);
    localparam int W = data_width;
    typedef enum logic {IDLE, MUL} state_t;
    state_t state_q, state_d;
    logic [3:0] op;
    logic [W-1:0] data_q, ma_q, cnt_q, res, wval, mres;
    logic [2*W-1:0] p_q, p_d, mprod;
    logic [W:0] sum, diff, msum;
    logic cy_q, ov_q, z_q, n_q, vld_q, neg_q;
    logic rcy, rov, wcy, wov, wr_en, accept, last, is_def, is_mul, is_nop, cin, start;
    assign op        = OP[3:0];
    assign is_def    = ((OP >> 4) == '0) && (op <= 4'd13);
    assign is_mul    = is_def && op == 4'd13;
    assign is_nop    = is_def && op == 4'd7;
    assign in_ready  = state_q == IDLE;
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign start     = accept && is_mul;
    assign last      = cnt_q == W'(W - 1);
    assign cin       = (op == 4'd8 || op == 4'd9) && cy_in;
    assign sum       = {1'b0, cr_in} + {1'b0, data_in} + {{W{1'b0}}, cin};
    assign diff      = {1'b0, cr_in} - {1'b0, data_in} - {{W{1'b0}}, cin};
    // one shift-add step: add multiplicand to the high half when the low bit is set, then shift right
    assign msum      = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, ma_q} : '0);
    assign p_d       = {msum, p_q[W-1:1]};
    assign mprod     = neg_q ? -p_d : p_d;
    assign mres      = mprod[W-1:0];
    assign out_valid = vld_q;
    assign data_out  = data_q;
    assign cy        = cy_q;
    assign ov        = ov_q;
    assign z         = z_q;
    assign n         = n_q;
    always_comb begin
        res = '0;
        rcy = 1'b0;
        rov = 1'b0;
        case (is_def ? op : 4'd15)
            4'd0: res = data_in;
            4'd1, 4'd8: begin
                res = sum[W-1:0];
                rcy = sum[W];
                rov = (cr_in[W-1] == data_in[W-1]) && (sum[W-1] != cr_in[W-1]);
            end
            4'd2, 4'd9: begin
                res = diff[W-1:0];
                rcy = diff[W];
                rov = (cr_in[W-1] != data_in[W-1]) && (diff[W-1] != cr_in[W-1]);
            end
            4'd3: res = cr_in & data_in;
            4'd4: res = cr_in | data_in;
            4'd5: res = cr_in ^ data_in;
            4'd6: res = ~data_in;
            4'd10: begin
                res = {data_in[W-2:0], 1'b0};
                rcy = data_in[W-1];
            end
            4'd11: begin
                res = {1'b0, data_in[W-1:1]};
                rcy = data_in[0];
            end
            4'd12: begin
                res = {data_in[W-1], data_in[W-1:1]};
                rcy = data_in[0];
            end
            default: ;
        endcase
    end
    always_comb begin
        state_d = state_q;
        wval    = res;
        wcy     = rcy;
        wov     = rov;
        wr_en   = accept && !is_mul && !is_nop;
        if (state_q == MUL) begin
            wval    = mres;
            wcy     = mprod != {{W{mres[W-1]}}, mres};
            wov     = wcy;
            wr_en   = last;
            state_d = last ? IDLE : MUL;
        end else if (start) begin
            state_d = MUL;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            vld_q   <= 1'b0;
            ma_q    <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= wr_en;
            if (wr_en) begin
                data_q <= wval;
                cy_q   <= wcy;
                ov_q   <= wov;
                z_q    <= wval == '0;
                n_q    <= wval[W-1];
            end
            if (state_q == IDLE && start) begin
                ma_q  <= cr_in[W-1] ? -cr_in : cr_in;
                p_q   <= {{W{1'b0}}, (data_in[W-1] ? -data_in : data_in)};
                neg_q <= cr_in[W-1] ^ data_in[W-1];
                cnt_q <= '0;
            end else if (state_q == MUL) begin
                p_q   <= p_d;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule
